// File: rtl/param_data_mem_pkg.sv
// Shared types and defaults for the parameterized data memory.
// Parity helper is only used when DMEM_PARITY_EN is defined.
package param_data_mem_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 9;
   localparam int DEPTH_DEF  = 512;
   localparam int PAR_MAX_W  = 64;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   // Even parity: the returned bit makes the total count of ones even.
   function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/param_data_mem_array.sv
// Storage for param_data_mem: one write port, one registered read port.
// The read register can also be loaded with zero for out-of-range reads.
module dmem_array #(
   parameter int WORD_W = 16,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic              rzero_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)        rdata_q <= '0;
      else if (re_i)    rdata_q <= mem_q[raddr_i];
      else if (rzero_i) rdata_q <= '0;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/param_data_mem.sv
// Word-addressed data memory that zeroes itself after reset, then serves
// single-cycle-latency reads and writes. Optional parity: DMEM_PARITY_EN.
module param_data_mem
   import param_data_mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     EN,
   input  logic                     WE,
   input  logic [ADDR_W-1:0]        ADDR,
   input  logic signed [DATA_W-1:0] in,
   output logic signed [DATA_W-1:0] out,
   output logic                     out_valid,
   output logic                     busy,
   output logic                     addr_err,
   output logic                     parity_err
);

`ifdef DMEM_PARITY_EN
   localparam int WORD_W = DATA_W + 1;
`else
   localparam int WORD_W = DATA_W;
`endif
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic              aerr_q, aerr_d;

   logic              accept, in_range;
   logic              mem_we, mem_re, mem_rzero;
   logic [ADDR_W-1:0] mem_waddr;
   logic [WORD_W-1:0] mem_wdata, wword, rword;

   // Compare in 32 bits so an out-of-range ADDR is never folded onto DEPTH.
   assign in_range = ({{(32-ADDR_W){1'b0}}, ADDR} < 32'(DEPTH));
   assign busy     = (state_q == ST_CLEAR);
   assign accept   = EN & ~busy;

`ifdef DMEM_PARITY_EN
   logic perr;
   assign wword      = {even_par(PAR_MAX_W'($unsigned(in))), in};
   assign perr       = even_par(PAR_MAX_W'(rword[DATA_W-1:0])) ^ rword[DATA_W];
   assign parity_err = valid_q & ~aerr_q & perr;
`else
   assign wword      = in;
   assign parity_err = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_waddr = ADDR;
      mem_wdata = wword;
      case (state_q)
         ST_CLEAR: begin
            // All-zero words are parity-correct, so no parity term here.
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            if (cnt_q == LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         ST_IDLE: mem_we = accept & WE & in_range;
         default: state_d = ST_CLEAR;
      endcase
      valid_d   = accept & ~WE;
      aerr_d    = accept & ~in_range;
      mem_re    = accept & ~WE & in_range;
      mem_rzero = accept & ~WE & ~in_range;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         aerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         aerr_q  <= aerr_d;
      end
   end

   dmem_array #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk_i   (CLK),
      .rst_i   (RST),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .re_i    (mem_re),
      .rzero_i (mem_rzero),
      .raddr_i (ADDR),
      .rdata_o (rword)
   );

   assign out       = rword[DATA_W-1:0];
   assign out_valid = valid_q;
   assign addr_err  = aerr_q;

endmodule

// File: tb/tb_param_data_mem.sv
// Directed bench for param_data_mem: a DEPTH=512 and a DEPTH=400 instance
// share stimulus. Parity flip test runs only with DMEM_PARITY_EN.
module tb_param_data_mem;

   logic               CLK, RST, EN, WE;
   logic [8:0]         ADDR;
   logic signed [15:0] din;

   logic signed [15:0] a_out, b_out;
   logic a_vld, a_busy, a_aerr, a_perr;
   logic b_vld, b_busy, b_aerr, b_perr;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc, vseen;

   param_data_mem u_dut (
      .CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .ADDR(ADDR), .in(din),
      .out(a_out), .out_valid(a_vld), .busy(a_busy),
      .addr_err(a_aerr), .parity_err(a_perr)
   );

   param_data_mem #(.DEPTH(400)) u_dut400 (
      .CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .ADDR(ADDR), .in(din),
      .out(b_out), .out_valid(b_vld), .busy(b_busy),
      .addr_err(b_aerr), .parity_err(b_perr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic req(input logic en, input logic we, input logic [8:0] addr,
                      input logic signed [15:0] d);
      EN = en; WE = we; ADDR = addr; din = d;
   endtask

   // Counts sampled cycles with busy high on the 512-deep instance.
   task automatic count_busy(output int c, output int vs);
      c  = 0;
      vs = 0;
      for (int i = 0; i < 2000 && a_busy; i++) begin
         c++;
         if (a_vld) vs = 1;
         tick();
      end
   endtask

   initial begin
      RST = 1'b1;
      req(0, 0, 0, 0);
      tick(); tick();
      chk("rst_out",   a_out,  0);
      chk("rst_vld",   a_vld,  0);
      chk("rst_aerr",  a_aerr, 0);
      chk("rst_perr",  a_perr, 0);
      chk("rst_busy",  a_busy, 1);

      // Clear with a read request held throughout
      RST = 1'b0;
      req(1, 0, 5, 0);
      count_busy(cyc, vseen);
      chk("busy_cycles", cyc, 512);
      chk("no_vld_busy", vseen, 0);
      chk("drop_last_clear_vld", a_vld, 0);
      tick();
      chk("first_read_vld", a_vld, 1);
      chk("first_read_out", a_out, 0);

      // Write then read-after-write
      req(1, 1, 123, 456);
      tick();
      chk("wr_no_vld", a_vld, 0);
      chk("wr_out_hold", a_out, 0);
      req(1, 0, 123, 0);
      tick();
      chk("raw_vld", a_vld, 1);
      chk("raw_out", a_out, 456);
      chk("raw_perr", a_perr, 0);
      req(0, 0, 0, 0);
      tick();
      chk("idle_vld", a_vld, 0);
      chk("idle_out_hold", a_out, 456);

      // Boundary words, back-to-back reads
      req(1, 1, 0, -16'sd7);
      tick();
      req(1, 1, 511, 16'sd32767);
      tick();
      req(1, 0, 0, 0);
      tick();
      chk("b2b0_vld", a_vld, 1);
      chk("b2b0_out", a_out, -7);
      req(1, 0, 511, 0);
      tick();
      chk("b2b1_vld", a_vld, 1);
      chk("b2b1_out", a_out, 32767);
      chk("b2b1_aerr", a_aerr, 0);

      // Out-of-range on the 400-deep instance
      req(1, 1, 50, 1234);
      tick();
      req(1, 1, 450, 99);
      tick();
      chk("oor_wr_aerr", b_aerr, 1);
      chk("oor_wr_vld", b_vld, 0);
      chk("inr_wr_aerr", a_aerr, 0);
      req(1, 0, 450, 0);
      tick();
      chk("oor_rd_vld", b_vld, 1);
      chk("oor_rd_out", b_out, 0);
      chk("oor_rd_aerr", b_aerr, 1);
      chk("inr_rd_out", a_out, 99);
      req(1, 0, 50, 0);
      tick();
      chk("nofold_out", b_out, 1234);
      chk("nofold_aerr", b_aerr, 0);
      req(0, 0, 0, 0);
      tick();
      chk("aerr_pulse_end", b_aerr, 0);

      // Reset with a read in flight, then reset again mid-clear
      RST = 1'b1;
      req(1, 0, 123, 0);
      tick();
      chk("rst_rd_vld", a_vld, 0);
      chk("rst_rd_out", a_out, 0);
      RST = 1'b0;
      req(0, 0, 0, 0);
      repeat (200) tick();
      chk("busy_mid_clear", a_busy, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      count_busy(cyc, vseen);
      chk("busy_restart", cyc, 512);
      req(1, 0, 511, 0);
      tick();
      chk("lost_511", a_out, 0);
      chk("lost_511_vld", a_vld, 1);
      req(1, 0, 123, 0);
      tick();
      chk("lost_123", a_out, 0);
      req(0, 0, 0, 0);
      tick();

`ifdef DMEM_PARITY_EN
      req(1, 1, 10, 77);
      tick();
      req(1, 0, 10, 0);
      tick();
      chk("par_clean_out", a_out, 77);
      chk("par_clean_err", a_perr, 0);
      req(0, 0, 0, 0);
      u_dut.u_mem.mem_q[10][3] = ~u_dut.u_mem.mem_q[10][3];
      tick();
      req(1, 0, 10, 0);
      tick();
      chk("par_flip_vld", a_vld, 1);
      chk("par_flip_err", a_perr, 1);
      req(0, 0, 0, 0);
      tick();
      chk("par_err_end", a_perr, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/param_data_mem.md
PARAM_DATA_MEM -- requirements
Module: param_data_mem

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits (signed data).
REQ-002 Parameter ADDR_W, default 9, address width in bits.
REQ-003 Parameter DEPTH, default 512, number of words, legal range 2..2**ADDR_W.
REQ-004 CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 EN  in  1  request strobe, one request per cycle when high.
REQ-007 WE  in  1  request type: 1 = write, 0 = read; sampled only with EN.
REQ-008 ADDR  in  ADDR_W  word address of the request.
REQ-009 in  in  DATA_W  signed write data.
REQ-010 out  out  DATA_W  signed registered read data.
REQ-011 out_valid  out  1  single-cycle pulse marking new data on out.
REQ-012 busy  out  1  high while the array is being cleared; requests are not accepted.
REQ-013 addr_err  out  1  pulses with out_valid, or one cycle after a write, when ADDR >= DEPTH.
REQ-014 parity_err  out  1  pulses with out_valid when the stored parity mismatches; tied 0 without DMEM_PARITY_EN.

Function
REQ-015 The FSM SHALL have states CLEAR and IDLE; reset enters CLEAR with clear counter 0.
REQ-016 In CLEAR, one word SHALL be zeroed per cycle at counter 0..DEPTH-1; after word DEPTH-1 the FSM moves to IDLE, so busy is high for exactly DEPTH cycles after RST falls.
REQ-017 Requests with EN high while busy SHALL be dropped: no write, no out_valid, no addr_err.
REQ-018 In IDLE, a write request with ADDR < DEPTH SHALL update the word at that clock edge; out and out_valid SHALL not change.
REQ-019 A read request SHALL produce out and out_valid=1 exactly one cycle later (latency 1); back-to-back reads SHALL give one result per cycle.
REQ-020 A read in the cycle after a write to the same address SHALL return the newly written value.
REQ-021 out SHALL hold its last value while out_valid is low.
REQ-022 A write with ADDR >= DEPTH SHALL not modify the array, and addr_err SHALL pulse one cycle later.
REQ-023 A read with ADDR >= DEPTH SHALL return out=0 with out_valid=1 and addr_err=1 in the same cycle.
REQ-024 Address arithmetic SHALL not wrap: no modulo folding of ADDR onto DEPTH.

Reset
REQ-025 While RST is high: out=0, out_valid=0, addr_err=0, parity_err=0, busy=1, FSM=CLEAR, counter=0.
REQ-026 RST asserted mid-clear or mid-read SHALL restart the clear from word 0 and discard any pending read result.

Configuration
REQ-027 With DMEM_PARITY_EN defined, each word SHALL store DATA_W+1 bits including an even-parity bit; each read recomputes parity and pulses parity_err on mismatch; cleared words carry correct parity.
REQ-028 Without DMEM_PARITY_EN, words SHALL be DATA_W bits and parity_err SHALL be constant 0.

Structure
REQ-029 Package param_data_mem_pkg SHALL hold the FSM state enum, the default parameter constants and the parity function.
REQ-030 Storage SHALL be a sub-module dmem_array (1 write port, 1 registered read port), instantiated once.

Verification
REQ-031 Release RST, hold EN=1 WE=0 ADDR=5 -> busy=1 for 512 cycles, no out_valid; first read after busy falls returns out=0.
REQ-032 After clear, write 456 at 123, then read 123 the next cycle -> out=456 with out_valid one cycle after the read request.
REQ-033 Write -7 at 0 and 32767 at 511, then read 0 and 511 back-to-back -> out=-7 then 32767 on consecutive cycles.
REQ-034 DEPTH=400: write 99 at 450 then read 450 -> addr_err after the write; out=0 with out_valid=1 and addr_err=1 after the read; word 50 unchanged.
REQ-035 Assert RST at clear cycle 200 for one cycle -> busy stays high for a further 512 cycles after RST falls; earlier writes are lost and read as 0.
REQ-036 With DMEM_PARITY_EN, force a single bit flip in stored word 10 -> read of 10 pulses parity_err with out_valid.
